ebus_diag_arb: RTL and testbench

EBUS_DIAG_ARB -- requirements
Module: ebus_diag_arb

---
 rtl/ebus_diag_arb_if.sv | 35 +++
 rtl/ebus_diag_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_ebus_diag_arb.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebus_diag_arb_if.sv
// Signal bundle between ebus_diag_arb, its two requesters and the EBUS diagnostic lines.
// slave is the arbiter's view; master is the view of the requesters and the bus model.
interface ebus_diag_arb_if;
  logic        req0;
  logic        req1;
  logic [1:0]  type0;
  logic [1:0]  type1;
  logic [6:0]  ds0;
  logic [6:0]  ds1;
  logic [35:0] wdata0;
  logic [35:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [35:0] rdata;
  logic        busy;
  logic [6:0]  ebus_ds;
  logic        ebus_diag_strobe;
  logic        ebus_drv_en;
  logic [35:0] ebus_drv_data;
  logic [35:0] ebus_data_in;

  modport slave (
    input  req0, req1, type0, type1, ds0, ds1, wdata0, wdata1, ebus_data_in,
    output gnt0, gnt1, done0, done1, rdata, busy,
           ebus_ds, ebus_diag_strobe, ebus_drv_en, ebus_drv_data
  );

  modport master (
    output req0, req1, type0, type1, ds0, ds1, wdata0, wdata1, ebus_data_in,
    input  gnt0, gnt1, done0, done1, rdata, busy,
           ebus_ds, ebus_diag_strobe, ebus_drv_en, ebus_drv_data
  );
endinterface

// File: rtl/ebus_diag_arb.sv
// Two-requester round-robin arbiter that runs EBUS diagnostic function/read/write cycles:
// a fixed-length strobe phase followed by an idle recovery gap, all outputs registered.
module ebus_diag_arb #(
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES    = 7,
  parameter logic [6:0]  DIAG_IDLE     = 7'h00
) (
  input  logic           clk,
  input  logic           CROBAR,
  ebus_diag_arb_if.slave bus
);

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES);
  localparam logic [1:0] TYPE_READ   = 2'd1;
  localparam logic [1:0] TYPE_WRITE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_nxt_s;
  logic        owner_r;
  logic        last_winner_r;
  logic [1:0]  type_r;
  logic [6:0]  ds_r;
  logic [35:0] wdata_r;
  logic [35:0] rdata_r;

  logic        win_s;
  logic        start_s;
  logic        leave_strobe_s;
  logic        finish_s;
  logic [1:0]  sel_type_s;
  logic [6:0]  sel_ds_s;
  logic [35:0] sel_wdata_s;

  logic        gnt0_r, gnt1_r, done0_r, done1_r, busy_r, strobe_r, drv_en_r;
  logic [6:0]  ebus_ds_r;
  logic [35:0] drv_data_r;
  logic        gnt0_nxt_s, gnt1_nxt_s, done0_nxt_s, done1_nxt_s;
  logic        busy_nxt_s, strobe_nxt_s, drv_en_nxt_s;
  logic [6:0]  ebus_ds_nxt_s;
  logic [35:0] drv_data_nxt_s;

  // Round-robin winner and the fields the transaction will carry (fresh on start, held otherwise).
  always_comb begin
    win_s       = 1'b0;
    start_s     = 1'b0;
    sel_type_s  = type_r;
    sel_ds_s    = ds_r;
    sel_wdata_s = wdata_r;
    if (bus.req0 && bus.req1) begin
      win_s = ~last_winner_r;
    end else begin
      win_s = bus.req1;
    end
    start_s = (state_r == ST_IDLE) && (bus.req0 || bus.req1);
    if (start_s) begin
      if (win_s) begin
        sel_type_s  = bus.type1;
        sel_ds_s    = bus.ds1;
        sel_wdata_s = bus.wdata1;
      end else begin
        sel_type_s  = bus.type0;
        sel_ds_s    = bus.ds0;
        sel_wdata_s = bus.wdata0;
      end
    end else begin
      sel_type_s  = type_r;
      sel_ds_s    = ds_r;
      sel_wdata_s = wdata_r;
    end
  end

  // Next state and phase counter; the counter runs 1..N inside STROBE and inside GAP.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    leave_strobe_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_STROBE;
          cnt_nxt_s   = 8'd1;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      end
      ST_STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          leave_strobe_s = 1'b1;
          if (GAP_LAST == 8'd0) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 8'd0;
          end else begin
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = 8'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from where the FSM is heading.
  always_comb begin
    finish_s       = (state_r != ST_IDLE) && (state_nxt_s == ST_IDLE);
    gnt0_nxt_s     = start_s && !win_s;
    gnt1_nxt_s     = start_s && win_s;
    done0_nxt_s    = finish_s && !owner_r;
    done1_nxt_s    = finish_s && owner_r;
    busy_nxt_s     = (state_nxt_s != ST_IDLE);
    strobe_nxt_s   = 1'b0;
    ebus_ds_nxt_s  = DIAG_IDLE;
    drv_en_nxt_s   = 1'b0;
    drv_data_nxt_s = 36'd0;
    if (state_nxt_s == ST_STROBE) begin
      strobe_nxt_s  = 1'b1;
      ebus_ds_nxt_s = sel_ds_s;
      if (sel_type_s == TYPE_WRITE) begin
        drv_en_nxt_s   = 1'b1;
        drv_data_nxt_s = sel_wdata_s;
      end else begin
        drv_en_nxt_s   = 1'b0;
        drv_data_nxt_s = 36'd0;
      end
    end else begin
      strobe_nxt_s   = 1'b0;
      ebus_ds_nxt_s  = DIAG_IDLE;
      drv_en_nxt_s   = 1'b0;
      drv_data_nxt_s = 36'd0;
    end
  end

  // FSM state, counter, captured transaction, fairness pointer and read result.
  always_ff @(posedge clk or negedge CROBAR) begin
    if (!CROBAR) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 8'd0;
      owner_r       <= 1'b0;
      last_winner_r <= 1'b1;
      type_r        <= 2'd0;
      ds_r          <= 7'd0;
      wdata_r       <= 36'd0;
      rdata_r       <= 36'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      type_r  <= sel_type_s;
      ds_r    <= sel_ds_s;
      wdata_r <= sel_wdata_s;
      if (start_s) begin
        owner_r <= win_s;
      end
      if (finish_s) begin
        last_winner_r <= owner_r;
      end
      if (leave_strobe_s && (type_r == TYPE_READ)) begin
        rdata_r <= bus.ebus_data_in;
      end
    end
  end

  // Output registers; reset releases the EBUS immediately.
  always_ff @(posedge clk or negedge CROBAR) begin
    if (!CROBAR) begin
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      busy_r     <= 1'b0;
      strobe_r   <= 1'b0;
      drv_en_r   <= 1'b0;
      ebus_ds_r  <= DIAG_IDLE;
      drv_data_r <= 36'd0;
    end else begin
      gnt0_r     <= gnt0_nxt_s;
      gnt1_r     <= gnt1_nxt_s;
      done0_r    <= done0_nxt_s;
      done1_r    <= done1_nxt_s;
      busy_r     <= busy_nxt_s;
      strobe_r   <= strobe_nxt_s;
      drv_en_r   <= drv_en_nxt_s;
      ebus_ds_r  <= ebus_ds_nxt_s;
      drv_data_r <= drv_data_nxt_s;
    end
  end

  assign bus.gnt0             = gnt0_r;
  assign bus.gnt1             = gnt1_r;
  assign bus.done0            = done0_r;
  assign bus.done1            = done1_r;
  assign bus.busy             = busy_r;
  assign bus.rdata            = rdata_r;
  assign bus.ebus_ds          = ebus_ds_r;
  assign bus.ebus_diag_strobe = strobe_r;
  assign bus.ebus_drv_en      = drv_en_r;
  assign bus.ebus_drv_data    = drv_data_r;

endmodule

// File: tb/tb_ebus_diag_arb.sv
// Bench for ebus_diag_arb: directed scenarios plus random requester traffic, checked against
// a transaction-timeline model (offsets from the arbitration cycle), and a fast 1/0 configuration.
module tb_ebus_diag_arb;
  localparam int         S         = 8;
  localparam int         G         = 7;
  localparam logic [6:0] IDLE_CODE = 7'h2A;

  logic clk    = 1'b0;
  logic CROBAR = 1'b1;
  always #5 clk = ~clk;

  ebus_diag_arb_if b1();
  ebus_diag_arb_if b2();

  ebus_diag_arb #(.STROBE_CYCLES(S), .GAP_CYCLES(G), .DIAG_IDLE(IDLE_CODE)) dut (
    .clk(clk), .CROBAR(CROBAR), .bus(b1));
  ebus_diag_arb #(.STROBE_CYCLES(1), .GAP_CYCLES(0), .DIAG_IDLE(7'h00)) dut_fast (
    .clk(clk), .CROBAR(CROBAR), .bus(b2));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: one transaction record, timed relative to the cycle in which it was arbitrated.
  logic        m_act  = 1'b0;
  int          m_t0   = 0;
  logic        m_own  = 1'b0;
  logic [1:0]  m_type = 2'd0;
  logic [6:0]  m_ds   = 7'd0;
  logic [35:0] m_wd   = 36'd0;
  logic [35:0] m_rd   = 36'd0;
  logic        m_last = 1'b1;
  int          m_dcyc = -1;
  logic        m_down = 1'b0;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0b expected %0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %o expected %o", tag, cyc, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply the rules for the edge that closes the current cycle, using this cycle's inputs.
  task automatic model_edge();
    if (m_act && (cyc == m_t0 + S) && (m_type == 2'd1)) m_rd = b1.ebus_data_in;
    if (m_act && (cyc >= m_t0 + S + G + 1)) begin
      m_act  = 1'b0;
      m_last = m_own;
    end
    if (!m_act && (b1.req0 || b1.req1)) begin
      m_own  = (b1.req0 && b1.req1) ? ~m_last : b1.req1;
      m_type = m_own ? b1.type1 : b1.type0;
      m_ds   = m_own ? b1.ds1 : b1.ds0;
      m_wd   = m_own ? b1.wdata1 : b1.wdata0;
      m_t0   = cyc;
      m_act  = 1'b1;
      m_dcyc = cyc + S + G + 1;
      m_down = m_own;
    end
  endtask

  task automatic check_all();
    int   k;
    logic in_s, in_b, wr;
    k    = cyc - m_t0;
    in_s = m_act && (k >= 1) && (k <= S);
    in_b = m_act && (k >= 1) && (k <= S + G);
    wr   = in_s && (m_type == 2'd2);
    chkb("gnt0", b1.gnt0, in_s && (k == 1) && !m_own);
    chkb("gnt1", b1.gnt1, in_s && (k == 1) && m_own);
    chkb("done0", b1.done0, (cyc == m_dcyc) && !m_down);
    chkb("done1", b1.done1, (cyc == m_dcyc) && m_down);
    chkb("busy", b1.busy, in_b);
    chkb("strobe", b1.ebus_diag_strobe, in_s);
    chkv("ds", 36'(b1.ebus_ds), in_s ? 36'(m_ds) : 36'(IDLE_CODE));
    chkb("drv_en", b1.ebus_drv_en, wr);
    chkv("drv_data", b1.ebus_drv_data, wr ? m_wd : 36'd0);
    chkv("rdata", b1.rdata, m_rd);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  // Asynchronous reset at the current time, held across one edge, released mid-cycle.
  task automatic reset_check();
    CROBAR = 1'b0;
    #1;
    m_act  = 1'b0;
    m_dcyc = -1;
    m_last = 1'b1;
    m_rd   = 36'd0;
    check_all();
    chkb("f_rst_busy", b2.busy, 1'b0);
    chkv("f_rst_ds", 36'(b2.ebus_ds), 36'd0);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    @(negedge clk);
    CROBAR = 1'b1;
  endtask

  task automatic drive_req(input logic r);
    logic cur, granted, nreq, fresh;
    cur     = r ? b1.req1 : b1.req0;
    granted = m_act && (cyc - m_t0 == 1) && (m_own == r);
    fresh   = granted || !cur;
    if (fresh) nreq = ($urandom_range(0, 3) == 0);
    else       nreq = ($urandom_range(0, 15) != 0);
    if (r) begin
      if (nreq && fresh) begin
        b1.type1  = 2'($urandom_range(0, 3));
        b1.ds1    = 7'($urandom);
        b1.wdata1 = {4'($urandom), $urandom};
      end
      b1.req1 = nreq;
    end else begin
      if (nreq && fresh) begin
        b1.type0  = 2'($urandom_range(0, 3));
        b1.ds0    = 7'($urandom);
        b1.wdata0 = {4'($urandom), $urandom};
      end
      b1.req0 = nreq;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int c0, g_at, d_at, n_str, n_drv, first_drv, ng, n_g;
    int g_cyc[8];
    logic g_own[8];

    b1.req0 = 1'b0; b1.req1 = 1'b0; b1.type0 = 2'd0; b1.type1 = 2'd0;
    b1.ds0 = 7'd0; b1.ds1 = 7'd0; b1.wdata0 = 36'd0; b1.wdata1 = 36'd0;
    b1.ebus_data_in = 36'd0;
    b2.req0 = 1'b0; b2.req1 = 1'b0; b2.type0 = 2'd0; b2.type1 = 2'd0;
    b2.ds0 = 7'd0; b2.ds1 = 7'd0; b2.wdata0 = 36'd0; b2.wdata1 = 36'd0;
    b2.ebus_data_in = 36'd0;
    #2;
    reset_check();

    // Single read from requester 0.
    c0 = cyc; g_at = -1; d_at = -1; n_str = 0;
    b1.req0 = 1'b1; b1.type0 = 2'd1; b1.ds0 = 7'o71; b1.wdata0 = 36'o101010101010;
    b1.ebus_data_in = 36'o123456701234;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (b1.gnt0 && (g_at < 0)) g_at = cyc - c0;
      if (b1.done0 && (d_at < 0)) d_at = cyc - c0;
      if (b1.ebus_diag_strobe) n_str++;
      if (cyc - c0 == 1) b1.req0 = 1'b0;
    end
    chki("rd_gnt_cycle", g_at, 1);
    chki("rd_done_cycle", d_at, 16);
    chki("rd_strobe_len", n_str, S);
    chkv("rd_rdata", b1.rdata, 36'o123456701234);

    // Single write from requester 1; read result must survive it.
    c0 = cyc; d_at = -1; n_drv = 0; first_drv = -1;
    b1.req1 = 1'b1; b1.type1 = 2'd2; b1.ds1 = 7'o61; b1.wdata1 = 36'o777000111222;
    for (int i = 0; i < 20; i++) begin
      b1.ebus_data_in = {4'($urandom), $urandom};
      cycle();
      if (b1.ebus_drv_en) begin
        n_drv++;
        if (first_drv < 0) first_drv = cyc - c0;
        chkv("wr_drv_data", b1.ebus_drv_data, 36'o777000111222);
      end
      if (b1.done1 && (d_at < 0)) d_at = cyc - c0;
      if (cyc - c0 == 1) b1.req1 = 1'b0;
    end
    chki("wr_drv_first", first_drv, 1);
    chki("wr_drv_len", n_drv, S);
    chki("wr_done_cycle", d_at, 16);
    chkv("wr_rdata_held", b1.rdata, 36'o123456701234);

    // Both requesters held from reset: grants alternate every 16 cycles.
    reset_check();
    c0 = cyc; ng = 0;
    for (int j = 0; j < 8; j++) begin g_cyc[j] = -1; g_own[j] = 1'b0; end
    b1.req0 = 1'b1; b1.type0 = 2'd0; b1.ds0 = 7'o13;
    b1.req1 = 1'b1; b1.type1 = 2'd3; b1.ds1 = 7'o14;
    for (int i = 0; i < 68; i++) begin
      b1.ebus_data_in = {4'($urandom), $urandom};
      cycle();
      if ((b1.gnt0 || b1.gnt1) && (ng < 8)) begin
        g_cyc[ng] = cyc - c0;
        g_own[ng] = b1.gnt1;
        ng++;
      end
    end
    chki("rr_count", ng, 5);
    for (int j = 0; j < 4; j++) begin
      chki("rr_cycle", g_cyc[j], 1 + 16 * j);
      chkb("rr_owner", g_own[j], 1'(j % 2));
    end
    b1.req0 = 1'b0; b1.req1 = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    // Reset during strobe cycle 4 of a write, then tie re-arbitration.
    b1.req0 = 1'b1; b1.type0 = 2'd2; b1.ds0 = 7'o44; b1.wdata0 = 36'o252525252525;
    for (int i = 0; i < 4; i++) cycle();
    chkb("mid_drv_before", b1.ebus_drv_en, 1'b1);
    reset_check();
    b1.req1 = 1'b1; b1.type1 = 2'd0; b1.ds1 = 7'o22;
    cycle();
    chkb("rst_regrant0", b1.gnt0, 1'b1);
    b1.req0 = 1'b0;

    // Random traffic from both requesters.
    for (int i = 0; i < 600; i++) begin
      b1.ebus_data_in = {4'($urandom), $urandom};
      drive_req(1'b0);
      drive_req(1'b1);
      cycle();
    end
    b1.req0 = 1'b0; b1.req1 = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    // Fast configuration: one strobe cycle, no gap.
    b2.req0 = 1'b1; b2.type0 = 2'd0; b2.ds0 = 7'o12;
    cycle();
    chkb("f_gnt0", b2.gnt0, 1'b1);
    chkb("f_strobe", b2.ebus_diag_strobe, 1'b1);
    chkv("f_ds", 36'(b2.ebus_ds), 36'(7'o12));
    b2.req0 = 1'b0;
    cycle();
    chkb("f_done0", b2.done0, 1'b1);
    chkb("f_strobe_off", b2.ebus_diag_strobe, 1'b0);
    chkb("f_busy_off", b2.busy, 1'b0);

    b2.req1 = 1'b1; b2.type1 = 2'd1; b2.ds1 = 7'o33; b2.ebus_data_in = 36'o555444333222;
    cycle();
    chkb("f_gnt1", b2.gnt1, 1'b1);
    b2.req1 = 1'b0; b2.req0 = 1'b1;
    cycle();
    chkb("f_done1", b2.done1, 1'b1);
    chkv("f_rdata", b2.rdata, 36'o555444333222);
    b2.req0 = 1'b0;
    n_g = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (b2.gnt0 || b2.gnt1 || b2.busy) n_g++;
    end
    chki("f_withdrawn", n_g, 0);

    b2.req1 = 1'b1; b2.type1 = 2'd0;
    cycle();
    chkb("f_gnt1_b", b2.gnt1, 1'b1);
    b2.req1 = 1'b0; b2.req0 = 1'b1;
    cycle();
    chkb("f_done1_b", b2.done1, 1'b1);
    cycle();
    chkb("f_held_gnt0", b2.gnt0, 1'b1);
    b2.req0 = 1'b0;
    cycle();
    chkb("f_held_done0", b2.done0, 1'b1);
    chkv("f_rdata_held", b2.rdata, 36'o555444333222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
